// File: rtl/axi_compare_ctrl.sv
// Run controller for the AXI slave-compare setup: sequences IDLE/RUN/DRAIN/DONE,
// gates master traffic, counts mismatch cycles and records the first mismatch.
module axi_compare_ctrl #(
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned CntWidth       = 16,
  parameter int unsigned DrainTimeout   = 1024,
  parameter bit          StopOnMismatch = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       clear_i,
  input  logic [2**AxiIdWidth-1:0]   aw_mismatch_i,
  input  logic                       w_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]   b_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]   ar_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]   r_mismatch_i,
  input  logic                       busy_i,
  output logic                       gate_o,
  output logic [1:0]                 state_o,
  output logic                       done_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [CntWidth-1:0]        err_cnt_o,
  output logic [2:0]                 first_chan_o,
  output logic [AxiIdWidth-1:0]      first_id_o
);

  localparam int NumIds = 2**AxiIdWidth;
  localparam int DrainW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [DrainW-1:0]     drain_cnt_q;
  logic [CntWidth-1:0]   err_cnt_q;
  logic                  fail_q, timeout_q, gate_q, done_q;
  logic [2:0]            first_chan_q;
  logic [AxiIdWidth-1:0] first_id_q;

  logic                  any_mm, timeout_hit, restart, count_en;
  logic [2:0]            cap_chan;
  logic [AxiIdWidth-1:0] cap_id;

  function automatic logic [AxiIdWidth-1:0] lowest_id(input logic [NumIds-1:0] v);
    lowest_id = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (v[i]) lowest_id = AxiIdWidth'(i);
    end
  endfunction

  assign any_mm = (|aw_mismatch_i) | w_mismatch_i | (|b_mismatch_i) |
                  (|ar_mismatch_i) | (|r_mismatch_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      gate_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN && state_d == DRAIN) ? drain_cnt_q + DrainW'(1) : '0;
      gate_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN:   if (stop_i || (StopOnMismatch && any_mm)) state_d = DRAIN;
      // An idle compare unit wins over a timeout landing in the same cycle.
      DRAIN: begin
        if (!busy_i) begin
          state_d = DONE;
        end else if (drain_cnt_q == DrainLast) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        if (start_i)      state_d = RUN;
        else if (clear_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    restart  = start_i && (state_q == IDLE || state_q == DONE);
    count_en = (state_q != IDLE);
    cap_chan = 3'd0;
    cap_id   = '0;
    if (|aw_mismatch_i) begin
      cap_chan = 3'd1;
      cap_id   = lowest_id(aw_mismatch_i);
    end else if (w_mismatch_i) begin
      cap_chan = 3'd2;
    end else if (|b_mismatch_i) begin
      cap_chan = 3'd3;
      cap_id   = lowest_id(b_mismatch_i);
    end else if (|ar_mismatch_i) begin
      cap_chan = 3'd4;
      cap_id   = lowest_id(ar_mismatch_i);
    end else if (|r_mismatch_i) begin
      cap_chan = 3'd5;
      cap_id   = lowest_id(r_mismatch_i);
    end
  end

  // Statistics: a restart clears everything and overrides any same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || restart) begin
      err_cnt_q    <= '0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      first_chan_q <= 3'd0;
      first_id_q   <= '0;
    end else begin
      if (count_en && any_mm) begin
        fail_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntWidth'(1);
        if (first_chan_q == 3'd0) begin
          first_chan_q <= cap_chan;
          first_id_q   <= cap_id;
        end
      end
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign state_o      = state_q;
  assign gate_o       = gate_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign err_cnt_o    = err_cnt_q;
  assign first_chan_o = first_chan_q;
  assign first_id_o   = first_id_q;

endmodule

// File: tb/tb_axi_compare_ctrl.sv
// Directed bench for axi_compare_ctrl: a stop-on-mismatch instance driven from a vector
// table plus hand sequences, and a second instance that keeps running on mismatches.
module tb_axi_compare_ctrl;

  typedef struct {
    logic       rst_n, start, stop, clear;
    logic [3:0] aw;
    logic       w;
    logic [3:0] b, ar, r;
    logic       busy;
    logic [1:0] st;
    logic       gate, done, fail, tmo;
    logic [3:0] cnt;
    logic [2:0] fc;
    logic [1:0] fi;
  } vec_t;

  logic       clk, rst_n, start, stop, clear, w, busy;
  logic [3:0] aw, b, ar, r;
  logic       gate, done, fail, tmo;
  logic [1:0] st;
  logic [3:0] cnt;
  logic [2:0] fc;
  logic [1:0] fi;

  logic       n_start, n_stop, n_clear, n_w;
  logic [3:0] n_aw, n_b, n_ar, n_r;
  logic       n_gate, n_done, n_fail, n_tmo;
  logic [1:0] n_st;
  logic [3:0] n_cnt;
  logic [2:0] n_fc;
  logic [1:0] n_fi;

  int total = 0;
  int bad   = 0;
  vec_t vecs[14];

  axi_compare_ctrl #(.AxiIdWidth(2), .CntWidth(4), .DrainTimeout(8), .StopOnMismatch(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .aw_mismatch_i(aw), .w_mismatch_i(w), .b_mismatch_i(b), .ar_mismatch_i(ar),
    .r_mismatch_i(r), .busy_i(busy), .gate_o(gate), .state_o(st), .done_o(done),
    .fail_o(fail), .timeout_o(tmo), .err_cnt_o(cnt), .first_chan_o(fc), .first_id_o(fi)
  );

  axi_compare_ctrl #(.AxiIdWidth(2), .CntWidth(4), .DrainTimeout(8), .StopOnMismatch(1'b0)) dut_nostop (
    .clk_i(clk), .rst_ni(rst_n), .start_i(n_start), .stop_i(n_stop), .clear_i(n_clear),
    .aw_mismatch_i(n_aw), .w_mismatch_i(n_w), .b_mismatch_i(n_b), .ar_mismatch_i(n_ar),
    .r_mismatch_i(n_r), .busy_i(busy), .gate_o(n_gate), .state_o(n_st), .done_o(n_done),
    .fail_o(n_fail), .timeout_o(n_tmo), .err_cnt_o(n_cnt), .first_chan_o(n_fc), .first_id_o(n_fi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rn, s, p, c, a, ww, bb, aa, rr, bz,
                              input int es, eg, ed, ef, et, ec, efc, efi);
    vec_t v;
    v.rst_n = 1'(rn); v.start = 1'(s); v.stop = 1'(p); v.clear = 1'(c);
    v.aw = 4'(a); v.w = 1'(ww); v.b = 4'(bb); v.ar = 4'(aa); v.r = 4'(rr); v.busy = 1'(bz);
    v.st = 2'(es); v.gate = 1'(eg); v.done = 1'(ed); v.fail = 1'(ef); v.tmo = 1'(et);
    v.cnt = 4'(ec); v.fc = 3'(efc); v.fi = 2'(efi);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    aw = '0; w = 1'b0; b = '0; ar = '0; r = '0;
    n_start = 1'b0; n_stop = 1'b0; n_clear = 1'b0;
    n_aw = '0; n_w = 1'b0; n_b = '0; n_ar = '0; n_r = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst_n; start = v.start; stop = v.stop; clear = v.clear;
    aw = v.aw; w = v.w; b = v.b; ar = v.ar; r = v.r; busy = v.busy;
    cyc();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("v%0d.state", idx), int'(st), int'(v.st));
    check($sformatf("v%0d.gate", idx), int'(gate), int'(v.gate));
    check($sformatf("v%0d.done", idx), int'(done), int'(v.done));
    check($sformatf("v%0d.fail", idx), int'(fail), int'(v.fail));
    check($sformatf("v%0d.timeout", idx), int'(tmo), int'(v.tmo));
    check($sformatf("v%0d.err_cnt", idx), int'(cnt), int'(v.cnt));
    check($sformatf("v%0d.first_chan", idx), int'(fc), int'(v.fc));
    check($sformatf("v%0d.first_id", idx), int'(fi), int'(v.fi));
  endtask

  initial begin
    //               rst st sp cl aw w  b  ar r  bz | st g  d  f  t  cnt fc fi
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 8, 0, 2, 1,  2, 0, 0, 1, 0, 1, 3, 3);
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1,  2, 0, 0, 1, 0, 2, 3, 3);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0, 2, 3, 3);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 4, 0, 0,  3, 0, 1, 1, 0, 3, 3, 3);
    vecs[8]  = mk(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1,  2, 0, 0, 1, 0, 1, 2, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0, 1, 2, 0);
    vecs[11] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 2, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 1, 2, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    busy = 1'b0;
    rst_n = 1'b0;
    cyc();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Drain timeout: DONE exactly 8 cycles after DRAIN entry with busy held high.
    idle_inputs(); busy = 1'b1; stop = 1'b1;
    cyc();
    check("to.enter_drain", int'(st), 2);
    stop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("to.state_k%0d", k), int'(st), (k == 8) ? 3 : 2);
    end
    check("to.timeout", int'(tmo), 1);

    // Same drain, but busy drops in the final drain cycle: no timeout.
    start = 1'b1;
    cyc();
    check("to2.restart_state", int'(st), 1);
    check("to2.restart_tmo", int'(tmo), 0);
    start = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      busy = (k == 8) ? 1'b0 : 1'b1;
      cyc();
    end
    check("to2.state", int'(st), 3);
    check("to2.timeout", int'(tmo), 0);

    // Saturation over RUN/DRAIN/DONE, then start+clear together restarts.
    start = 1'b1;
    cyc();
    start = 1'b0; busy = 1'b1; w = 1'b1;
    for (int k = 1; k <= 20; k++) cyc();
    check("sat.err_cnt", int'(cnt), 15);
    check("sat.state", int'(st), 3);
    check("sat.timeout", int'(tmo), 1);
    check("sat.first_chan", int'(fc), 2);
    w = 1'b0; start = 1'b1; clear = 1'b1;
    cyc();
    start = 1'b0; clear = 1'b0;
    check("rs.state", int'(st), 1);
    check("rs.gate", int'(gate), 1);
    check("rs.err_cnt", int'(cnt), 0);
    check("rs.fail", int'(fail), 0);
    check("rs.timeout", int'(tmo), 0);

    // Reset during DRAIN.
    w = 1'b1;
    cyc();
    w = 1'b0;
    check("rst.pre_state", int'(st), 2);
    check("rst.pre_cnt", int'(cnt), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checkOutput(vecs[0], 100);

    // Clean session: stop, busy falls after 3 drain cycles.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 20; k++) cyc();
    check("clean.run", int'(st), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    check("clean.still_drain", int'(st), 2);
    busy = 1'b0;
    cyc();
    check("clean.done", int'(done), 1);
    check("clean.state", int'(st), 3);
    check("clean.fail", int'(fail), 0);
    check("clean.err_cnt", int'(cnt), 0);
    check("clean.first_chan", int'(fc), 0);

    // Non-stopping instance: priority/capture, then stop and mismatch together.
    n_start = 1'b1;
    cyc();
    n_start = 1'b0;
    check("ns.run", int'(n_st), 1);
    n_b = 4'b1000; n_r = 4'b0010;
    cyc();
    n_b = '0; n_r = '0;
    check("ns.state1", int'(n_st), 1);
    check("ns.gate1", int'(n_gate), 1);
    check("ns.first_chan", int'(n_fc), 3);
    check("ns.first_id", int'(n_fi), 3);
    n_aw = 4'b0001;
    cyc();
    n_aw = '0;
    check("ns.first_chan2", int'(n_fc), 3);
    check("ns.first_id2", int'(n_fi), 3);
    check("ns.err_cnt2", int'(n_cnt), 2);
    n_stop = 1'b1; n_ar = 4'b0100;
    cyc();
    n_stop = 1'b0; n_ar = '0;
    check("ns.drain", int'(n_st), 2);
    check("ns.err_cnt3", int'(n_cnt), 3);
    check("ns.fail", int'(n_fail), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
